// File: rtl/frv_dmem_responder.sv
// Word-addressed data memory responder: grants requests, applies an optional fixed wait
// latency and returns responses in order through a two-entry response queue.
module frv_dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_addr,
    output logic        dmem_gnt,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata
);

    localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  WaitInit  = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [32:0] held_q, held_d;
    logic [32:0] fifo0_q, fifo0_d;
    logic [32:0] fifo1_q, fifo1_d;
    logic [1:0]  count_q, count_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic            accept;
    logic            pop;
    logic            push;
    logic            mem_we;
    logic [32:0]     acc_rsp;
    logic [32:0]     push_rsp;

    // The 33-bit compare keeps the range check exact even when the window ends at 2^32.
    assign offset   = dmem_addr - BASE_ADDR;
    assign in_range = (dmem_addr >= BASE_ADDR) && ({1'b0, offset} < SpanBytes);
    assign idx      = offset[IdxW+1:2];

    assign dmem_gnt = dmem_req && g_resetn && (state_q == StIdle) && (count_q != 2'd2);
    assign accept   = dmem_gnt;
    assign pop      = dmem_recv && dmem_ack;
    assign mem_we   = accept && dmem_wen && in_range;

    assign dmem_recv                = (count_q != 2'd0);
    assign {dmem_error, dmem_rdata} = dmem_recv ? fifo0_q : 33'd0;

    always_comb begin
        acc_rsp = 33'd0;
        if (!in_range) begin
            acc_rsp = {1'b1, 32'd0};
        end else if (!dmem_wen) begin
            acc_rsp = {1'b0, mem[idx]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        held_d   = held_q;
        push     = 1'b0;
        push_rsp = acc_rsp;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        push = 1'b1;
                    end else begin
                        held_d  = acc_rsp;
                        cnt_d   = WaitInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                push_rsp = held_q;
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if ((count_q != 2'd2) || pop) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b01: begin
                fifo0_d = fifo1_q;
                fifo1_d = 33'd0;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    fifo0_d = push_rsp;
                end else begin
                    fifo1_d = push_rsp;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    fifo0_d = push_rsp;
                end else begin
                    fifo0_d = fifo1_q;
                    fifo1_d = push_rsp;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            held_q  <= 33'd0;
            fifo0_q <= 33'd0;
            fifo1_q <= 33'd0;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            fifo0_q <= fifo0_d;
            fifo1_q <= fifo1_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_strb[i]) begin
                    mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
